pipeline_hazard_controller: RTL and testbench
=============================================

// Module: pipeline_hazard_controller
// PURPOSE
//   Central stall/flush controller for the five pipeline registers of the RISC15 core.
//   It detects load-use hazards between ID and EX, and control-flow redirects from EX
//   (branch/jump) and WB (R7 write).
//   It sequences LM/SM instructions one register per cycle by holding IF/ID while ID/EX
//   receives one micro-op per register.
//   Outputs drive PC/IF-ID hold and NOP-insert/flush of the IF/ID, ID/EX and EX/MEM registers.
// PARAMETERS
//   NREGS    8   width of the LM/SM register list (one bit per GPR)
//   REG_AW   3   register address width; REG_AW = clog2(NREGS)
// PORTS
//   clk            in   1       rising-edge clock
//   reset          in   1       asynchronous reset, active-high
//   id_valid       in   1       ID stage holds a real (non-NOP) instruction
//   id_uses_a      in   1       ID instruction reads id_src_a
//   id_uses_b      in   1       ID instruction reads id_src_b
//   id_src_a       in   REG_AW  ID source register A
//   id_src_b       in   REG_AW  ID source register B
//   id_is_multi    in   1       ID instruction is LM or SM
//   id_reg_list    in   NREGS   LM/SM register list (bit i = Ri)
//   ex_valid       in   1       EX stage holds a real instruction
//   ex_is_load     in   1       EX instruction is LW/LM (data available after MEM)
//   ex_writes_rf   in   1       EX instruction writes the register file
//   ex_dest        in   REG_AW  EX destination register
//   ex_redirect    in   1       branch/jump resolved taken in EX this cycle
//   wb_redirect    in   1       WB writes R7 this cycle (PC redirect)
//   stall_if       out  1       hold PC and IF/ID contents
//   bubble_ex      out  1       load NOP into ID/EX instead of the ID instruction
//   flush_if_id    out  1       replace IF/ID with NOP next edge
//   flush_id_ex    out  1       replace ID/EX with NOP next edge
//   flush_ex_mem   out  1       replace EX/MEM with NOP next edge
//   multi_busy     out  1       LM/SM sequence in progress (state MULTI)
//   multi_reg      out  REG_AW  register index of the current LM/SM micro-op
//   multi_first    out  1       current micro-op is the first of its LM/SM
//   multi_last     out  1       current micro-op is the last of its LM/SM
// BEHAVIOUR
//   Reset: state=IDLE, remaining list=0.
//     All outputs 0 while reset is high and in the first cycle after reset with idle inputs.
//   Outputs are combinational from the registered state and current inputs.
//     The state changes only on the clk rising edge.
//   Priority (highest first): wb_redirect > ex_redirect > load-use > LM/SM sequencing.
//   wb_redirect=1:
//     flush_if_id=flush_id_ex=flush_ex_mem=1; stall_if=0; bubble_ex=0.
//     Any MULTI sequence is aborted: next state IDLE, remaining=0.
//   ex_redirect=1 (and wb_redirect=0):
//     flush_if_id=flush_id_ex=1; flush_ex_mem=0; stall_if=0; abort MULTI as above.
//   Load-use:
//     hit = id_valid & ex_valid & ex_is_load & ex_writes_rf &
//           ((id_uses_a & id_src_a==ex_dest) | (id_uses_b & id_src_b==ex_dest)).
//     Evaluated only in state IDLE.
//     Response: stall_if=1, bubble_ex=1 for exactly one cycle (the next cycle EX holds the bubble).
//     An LM/SM in ID does not start while hit=1.
//   LM/SM, state IDLE:
//     Trigger: id_valid & id_is_multi & no higher-priority event.
//     multi_reg = index of the lowest set bit of id_reg_list; multi_first=1.
//     id_reg_list with exactly one bit set: multi_last=1, stall_if=0, stay IDLE.
//     id_reg_list with two or more bits set: stall_if=1; next state MULTI;
//       remaining = id_reg_list with the lowest set bit cleared.
//     id_reg_list == 0: multi_first=multi_last=1, multi_reg=0, bubble_ex=1; no stall; stay IDLE.
//   LM/SM, state MULTI:
//     multi_busy=1; multi_reg = lowest set bit of remaining; multi_first=0.
//     Exactly one bit left: multi_last=1, stall_if=0, next state IDLE.
//     Otherwise: stall_if=1; clear that bit from remaining.
//     id_* inputs are ignored in MULTI (IF/ID is held).
//   Throughput: N set bits produce N micro-ops in N consecutive cycles and N-1 stall cycles.
//   An all-ones list (0xFF) produces 8 micro-ops, R0..R7 in ascending order.
//   Redirect in the same cycle as a load-use hit or LM/SM start: the redirect wins;
//     no stall, no bubble.
//   Reset asserted mid-sequence: immediate return to IDLE; outputs 0 asynchronously.
// TESTING
//   1. EX=LW R3 (ex_is_load=1, ex_dest=3); ID=ADD src_a=3 ->
//        stall_if=1, bubble_ex=1 for 1 cycle; 0 on the next cycle.
//   2. ID=LM list=8'b1010_0100 ->
//        multi_reg 2,5,7 on 3 consecutive cycles; first=1 on cycle 1, last=1 on cycle 3;
//        stall_if=1,1,0.
//   3. LM list=8'hFF; pulse ex_redirect on micro-op 3 ->
//        flush_if_id=flush_id_ex=1 that cycle; multi_busy=0 on the next cycle; no more micro-ops.
//   4. wb_redirect and ex_redirect together with a load-use hit ->
//        all three flush outputs 1; stall_if=0; bubble_ex=0.
//   5. Assert reset during MULTI (list 8'h0F, after micro-op 1) ->
//        outputs 0 immediately.
//        After release, ID=LM list=8'h01 -> single micro-op, multi_reg=0, first=last=1, no stall.
//   6. Load-use with id_uses_a=0 and src_a matching, or with ex_writes_rf=0 -> no stall.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush controller for the RISC15 five-stage pipeline: load-use interlock,
// EX/WB redirect flushing and one-register-per-cycle LM/SM micro-op sequencing.
module pipeline_hazard_controller #(
  parameter int NREGS  = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              id_uses_a,
  input  logic              id_uses_b,
  input  logic [REG_AW-1:0] id_src_a,
  input  logic [REG_AW-1:0] id_src_b,
  input  logic              id_is_multi,
  input  logic [NREGS-1:0]  id_reg_list,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic              ex_writes_rf,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_redirect,
  input  logic              wb_redirect,
  output logic              stall_if,
  output logic              bubble_ex,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              flush_ex_mem,
  output logic              multi_busy,
  output logic [REG_AW-1:0] multi_reg,
  output logic              multi_first,
  output logic              multi_last
);

  typedef enum logic {
    S_IDLE,
    S_MULTI
  } state_t;

  state_t            state_q, state_d;
  logic [NREGS-1:0]  rem_q, rem_d;
  logic              load_use_hit;
  logic [NREGS-1:0]  list_rest;
  logic [NREGS-1:0]  rem_rest;

  function automatic logic [REG_AW-1:0] lowest_idx(input logic [NREGS-1:0] v);
    lowest_idx = '0;
    for (int unsigned i = NREGS; i > 0; i--) begin
      if (v[i-1]) lowest_idx = REG_AW'(i - 1);
    end
  endfunction

  // Clearing the lowest set bit; a zero result means exactly one bit was set.
  assign list_rest = id_reg_list & (id_reg_list - NREGS'(1));
  assign rem_rest  = rem_q & (rem_q - NREGS'(1));

  assign load_use_hit = id_valid & ex_valid & ex_is_load & ex_writes_rf &
                        ((id_uses_a & (id_src_a == ex_dest)) |
                         (id_uses_b & (id_src_b == ex_dest)));

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    stall_if     = 1'b0;
    bubble_ex    = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    multi_busy   = 1'b0;
    multi_reg    = '0;
    multi_first  = 1'b0;
    multi_last   = 1'b0;
    // Outputs are forced low while reset is held, independent of the clock.
    if (!reset) begin
      multi_busy = (state_q == S_MULTI);
      if (wb_redirect) begin
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
        flush_ex_mem = 1'b1;
        state_d      = S_IDLE;
        rem_d        = '0;
      end else if (ex_redirect) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        state_d     = S_IDLE;
        rem_d       = '0;
      end else if (state_q == S_MULTI) begin
        multi_reg = lowest_idx(rem_q);
        if (rem_rest == '0) begin
          multi_last = 1'b1;
          state_d    = S_IDLE;
          rem_d      = '0;
        end else begin
          stall_if = 1'b1;
          rem_d    = rem_rest;
        end
      end else if (load_use_hit) begin
        stall_if  = 1'b1;
        bubble_ex = 1'b1;
      end else if (id_valid && id_is_multi) begin
        multi_first = 1'b1;
        if (id_reg_list == '0) begin
          multi_last = 1'b1;
          bubble_ex  = 1'b1;
        end else begin
          multi_reg = lowest_idx(id_reg_list);
          if (list_rest == '0) begin
            multi_last = 1'b1;
          end else begin
            stall_if = 1'b1;
            state_d  = S_MULTI;
            rem_d    = list_rest;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: queue-based reference model checked
// every cycle, plus literal expectations for the hand-worked scenarios.
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_uses_a, id_uses_b, id_is_multi;
  logic [2:0] id_src_a, id_src_b, ex_dest;
  logic [7:0] id_reg_list;
  logic       ex_valid, ex_is_load, ex_writes_rf, ex_redirect, wb_redirect;
  logic       stall_if, bubble_ex, flush_if_id, flush_id_ex, flush_ex_mem;
  logic       multi_busy, multi_first, multi_last;
  logic [2:0] multi_reg;
  logic [10:0] outv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.NREGS(8), .REG_AW(3)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_uses_a(id_uses_a), .id_uses_b(id_uses_b),
    .id_src_a(id_src_a), .id_src_b(id_src_b),
    .id_is_multi(id_is_multi), .id_reg_list(id_reg_list),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_writes_rf(ex_writes_rf),
    .ex_dest(ex_dest), .ex_redirect(ex_redirect), .wb_redirect(wb_redirect),
    .stall_if(stall_if), .bubble_ex(bubble_ex), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .multi_busy(multi_busy), .multi_reg(multi_reg),
    .multi_first(multi_first), .multi_last(multi_last)
  );

  assign outv = {stall_if, bubble_ex, flush_if_id, flush_id_ex, flush_ex_mem,
                 multi_busy, multi_reg, multi_first, multi_last};

  function automatic logic [10:0] pk(input logic st, input logic bu, input logic f1,
                                     input logic f2, input logic f3, input logic busy,
                                     input logic [2:0] rg, input logic fi, input logic la);
    return {st, bu, f1, f2, f3, busy, rg, fi, la};
  endfunction

  task automatic cmp(input string name, input logic [10:0] exp);
    checks++;
    if (outv !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b (stall,bub,fif,fide,fexm,busy,reg,first,last) t=%0t",
               name, outv, exp, $time);
    end
  endtask

  // Reference model: pending micro-op register indices, in issue order.
  int mq[$];

  always @(negedge clk) begin
    logic st, bu, f1, f2, f3, busy, fi, la, hit;
    logic [2:0] rg;
    int nq[$];
    int l[$];
    {st, bu, f1, f2, f3, busy, fi, la} = '0;
    rg = '0;
    nq = {};
    l = {};
    if (!reset) begin
      busy = (mq.size() > 0);
      hit = id_valid && ex_valid && ex_is_load && ex_writes_rf &&
            ((id_uses_a && id_src_a == ex_dest) || (id_uses_b && id_src_b == ex_dest));
      if (wb_redirect) begin
        f1 = 1; f2 = 1; f3 = 1;
      end else if (ex_redirect) begin
        f1 = 1; f2 = 1;
      end else if (busy) begin
        rg = 3'(mq[0]);
        la = (mq.size() == 1);
        st = !la;
        nq = mq;
        void'(nq.pop_front());
      end else if (hit) begin
        st = 1; bu = 1;
      end else if (id_valid && id_is_multi) begin
        for (int i = 0; i < 8; i++) if (id_reg_list[i]) l.push_back(i);
        fi = 1;
        if (l.size() == 0) begin
          la = 1; bu = 1;
        end else begin
          rg = 3'(l[0]);
          la = (l.size() == 1);
          st = !la;
          nq = l;
          void'(nq.pop_front());
        end
      end
    end
    cmp("model", pk(st, bu, f1, f2, f3, busy, rg, fi, la));
    mq = nq;
  end

  task automatic idle_in();
    id_valid = 0; id_uses_a = 0; id_uses_b = 0; id_src_a = 0; id_src_b = 0;
    id_is_multi = 0; id_reg_list = 0;
    ex_valid = 0; ex_is_load = 0; ex_writes_rf = 0; ex_dest = 0;
    ex_redirect = 0; wb_redirect = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lm(input logic [7:0] list);
    id_valid = 1; id_is_multi = 1; id_reg_list = list;
  endtask

  task automatic ld_ex(input logic [2:0] dest);
    ex_valid = 1; ex_is_load = 1; ex_writes_rf = 1; ex_dest = dest;
  endtask

  initial begin
    reset = 1;
    idle_in();
    #2 cmp("reset_held", '0);
    tick(); tick();
    reset = 0;
    #2 cmp("post_reset_idle", '0);

    // Load-use on src_a
    tick(); idle_in(); ld_ex(3); id_valid = 1; id_uses_a = 1; id_src_a = 3;
    #2 cmp("lu_hit_a", pk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    tick(); ex_valid = 0; ex_is_load = 0;
    #2 cmp("lu_after_bubble", '0);
    // Non-hits: uses_a clear, writes_rf clear; then a hit on src_b
    tick(); idle_in(); ld_ex(3); id_valid = 1; id_src_a = 3; id_uses_b = 1; id_src_b = 4;
    #2 cmp("lu_no_use_a", '0);
    tick(); idle_in(); ld_ex(3); ex_writes_rf = 0; id_valid = 1; id_uses_a = 1; id_src_a = 3;
    #2 cmp("lu_no_write", '0);
    tick(); idle_in(); ld_ex(5); id_valid = 1; id_uses_b = 1; id_src_b = 5;
    #2 cmp("lu_hit_b", pk(1, 1, 0, 0, 0, 0, 0, 0, 0));

    // LM 1010_0100 -> R2, R5, R7; ID contents ignored once sequencing
    tick(); idle_in(); lm(8'b1010_0100);
    #2 cmp("lm_op1", pk(1, 0, 0, 0, 0, 0, 3'd2, 1, 0));
    tick(); id_reg_list = 8'hFF; ld_ex(1); id_uses_a = 1; id_src_a = 1;
    #2 cmp("lm_op2", pk(1, 0, 0, 0, 0, 1, 3'd5, 0, 0));
    tick();
    #2 cmp("lm_op3", pk(0, 0, 0, 0, 0, 1, 3'd7, 0, 1));
    tick(); idle_in();
    #2 cmp("lm_done", '0);

    // LM 0xFF aborted by ex_redirect on micro-op 3
    tick(); lm(8'hFF);
    #2 cmp("ff_op1", pk(1, 0, 0, 0, 0, 0, 3'd0, 1, 0));
    tick();
    #2 cmp("ff_op2", pk(1, 0, 0, 0, 0, 1, 3'd1, 0, 0));
    tick(); ex_redirect = 1;
    #2 cmp("ff_redirect", pk(0, 0, 1, 1, 0, 1, 3'd0, 0, 0));
    tick(); idle_in();
    #2 cmp("ff_aborted", '0);

    // Both redirects plus a load-use hit
    tick(); ld_ex(2); id_valid = 1; id_uses_a = 1; id_src_a = 2;
    wb_redirect = 1; ex_redirect = 1;
    #2 cmp("wb_ex_lu", pk(0, 0, 1, 1, 1, 0, 0, 0, 0));
    // ex_redirect beats an LM start
    tick(); idle_in(); lm(8'b1010_0100); ex_redirect = 1;
    #2 cmp("ex_vs_lm", pk(0, 0, 1, 1, 0, 0, 0, 0, 0));
    tick(); idle_in();
    #2 cmp("ex_vs_lm_after", '0);

    // Full 0xFF sequence: R0..R7 ascending, last on R7
    tick(); lm(8'hFF);
    for (int i = 0; i < 8; i++) begin
      #2 cmp("ff_full", pk(i != 7, 0, 0, 0, 0, i != 0, 3'(i), i == 0, i == 7));
      tick();
      if (i == 0) idle_in();
    end
    #2 cmp("ff_full_done", '0);

    // Reset during MULTI (0x0F after micro-op 1)
    tick(); lm(8'h0F);
    #2 cmp("rst_op1", pk(1, 0, 0, 0, 0, 0, 3'd0, 1, 0));
    tick();
    #1 reset = 1;
    #1 cmp("rst_async", '0);
    tick(); tick();
    reset = 0; idle_in(); lm(8'h01);
    #2 cmp("single_r0", pk(0, 0, 0, 0, 0, 0, 3'd0, 1, 1));

    // Empty list and single high register
    tick(); lm(8'h00);
    #2 cmp("empty_list", pk(0, 1, 0, 0, 0, 0, 3'd0, 1, 1));
    tick(); lm(8'h80);
    #2 cmp("single_r7", pk(0, 0, 0, 0, 0, 0, 3'd7, 1, 1));
    tick(); idle_in();
    #2 cmp("final_idle", '0);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
